// File: rtl/adder_tree_csa_pipe.sv
// adder_tree_csa_pipe: pipelined 3:2 carry-save adder tree with valid/ready flow control.
// Define ADDER_TREE_ACC_EN to add a per-frame accumulator after the final adder.
module adder_tree_csa_pipe #(
    parameter int I_DATA_W  = 3,
    parameter int I_DATA_N  = 22,
    parameter int SIGNED    = 0,
    parameter int ACC_EXT_W = 8,
`ifdef ADDER_TREE_ACC_EN
    localparam bit ACC_EN   = 1'b1,
`else
    localparam bit ACC_EN   = 1'b0,
`endif
    localparam int O_DATA_W = I_DATA_W + $clog2(I_DATA_N),
    localparam int OUT_W    = O_DATA_W + (ACC_EN ? ACC_EXT_W : 0)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [0:I_DATA_N-1][I_DATA_W-1:0]    i_data,
    input  logic                                 i_last,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [OUT_W-1:0]                     o_data,
    output logic                                 o_last
);
    function automatic int level_cnt(input int k);
        int n = I_DATA_N;
        for (int s = 0; s < k; s++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction
    function automatic int stage_cnt();
        int n = I_DATA_N;
        int s = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            s++;
        end
        return s;
    endfunction
    localparam int STAGES_N = stage_cnt();
    localparam int LATENCY  = STAGES_N + 1;
    logic                stall;
    logic [LATENCY-1:0]  vld, lst;
    logic [O_DATA_W-1:0] sum;
    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;
    always_ff @(posedge clk)
        if (rst) begin
            vld <= '0;
            lst <= '0;
        end else if (!stall) begin
            vld[0] <= i_valid;
            lst[0] <= i_valid & i_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                lst[i] <= lst[i-1];
            end
        end
    // Level 0 is the combinational width extension; levels 1..STAGES_N are registered CSA rows.
    for (genvar k = 0; k <= STAGES_N; k++) begin : lv
        localparam int CNT = level_cnt(k);
        logic [O_DATA_W-1:0] ops [CNT];
        if (k == 0) begin : g_ext
            for (genvar i = 0; i < CNT; i++) begin : g_w
                assign ops[i] = {{(O_DATA_W-I_DATA_W){SIGNED != 0 && i_data[i][I_DATA_W-1]}}, i_data[i]};
            end
        end else begin : g_csa
            localparam int PREV = level_cnt(k - 1);
            localparam int GRP  = PREV / 3;
            always_ff @(posedge clk)
                if (!stall) begin
                    for (int i = 0; i < GRP; i++) begin
                        ops[2*i]   <= lv[k-1].ops[3*i] ^ lv[k-1].ops[3*i+1] ^ lv[k-1].ops[3*i+2];
                        ops[2*i+1] <= ((lv[k-1].ops[3*i] & lv[k-1].ops[3*i+1]) |
                                       (lv[k-1].ops[3*i] & lv[k-1].ops[3*i+2]) |
                                       (lv[k-1].ops[3*i+1] & lv[k-1].ops[3*i+2])) << 1;
                    end
                    for (int j = 0; j < PREV % 3; j++) ops[2*GRP+j] <= lv[k-1].ops[3*GRP+j];
                end
        end
    end
    always_ff @(posedge clk)
        if (rst) sum <= '0;
        else if (!stall) sum <= lv[STAGES_N].ops[0] + lv[STAGES_N].ops[1];
`ifdef ADDER_TREE_ACC_EN
    logic [OUT_W-1:0] acc;
    logic             first, acc_vld;
    always_ff @(posedge clk)
        if (rst) begin
            acc     <= '0;
            first   <= 1'b1;
            acc_vld <= 1'b0;
        end else if (!stall) begin
            acc_vld <= vld[LATENCY-1] & lst[LATENCY-1];
            if (vld[LATENCY-1]) begin
                acc   <= (first ? '0 : acc) + {{ACC_EXT_W{SIGNED != 0 && sum[O_DATA_W-1]}}, sum};
                first <= lst[LATENCY-1];
            end
        end
    assign o_data  = acc;
    assign o_valid = acc_vld;
    assign o_last  = acc_vld;
`else
    assign o_data  = sum;
    assign o_valid = vld[LATENCY-1];
    assign o_last  = lst[LATENCY-1];
`endif
endmodule
